// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  localparam int         CNT_W_DEF = 32;
  localparam logic [4:0] REG_X0    = 5'd0;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that wins over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                  q <= '0;
    else if (clr)               q <= '0;
    else if (inc && (q != '1))  q <= q + ONE;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Stage enable/flush sequencing for load-use, taken-branch and memory-wait
// hazards, with a memory-wait watchdog and stall/flush performance counters.
//
// state       | meaning
// ST_RUN      | pipeline flows; no access outstanding beyond this cycle
// ST_MEM_WAIT | data memory busy, pipeline frozen, wait_cnt counts frozen cycles
// ST_ERROR    | access declared hung; frozen until reset
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             memwb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] wait_cnt, wait_nxt;
  logic        timeout_nxt;
  logic        freeze, lu, br;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_nxt;
      mem_timeout <= timeout_nxt;
    end
  end

  always_comb begin
    freeze = (mem_req & ~mem_ready) | (state == ST_ERROR);
    lu     = ex_memread && (ex_rd != REG_X0) &&
             ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    br     = ex_branch_taken;

    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;

    // Reset parks every stage register: nothing advances, bubbles everywhere.
    if (!rstn) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
    end else if (freeze) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_flush = 1'b1;
    end else if (br) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (lu) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_flush  = 1'b1;
    end

    state_nxt   = state;
    wait_nxt    = wait_cnt;
    timeout_nxt = mem_timeout;
    case (state)
      ST_RUN: begin
        if (mem_req && !mem_ready) begin
          state_nxt = ST_MEM_WAIT;
          wait_nxt  = 16'd1;
        end
      end
      ST_MEM_WAIT: begin
        // An abort is treated like completion so the core is never left frozen.
        if (!mem_req || mem_ready) begin
          state_nxt = ST_RUN;
          wait_nxt  = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt   = ST_ERROR;
          timeout_nxt = 1'b1;
        end else begin
          wait_nxt = wait_cnt + 16'd1;
        end
      end
      ST_ERROR: ;
      default: begin
        state_nxt = ST_RUN;
        wait_nxt  = '0;
      end
    endcase
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (cnt_clr),
    .inc  (~pc_write),
    .q    (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (cnt_clr),
    .inc  (br & ~freeze),
    .q    (flush_cnt)
  );
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I core. It sequences the stage-register enables and flushes that the forwarding unit cannot resolve:
  - load-use bubbles,
  - taken-branch squashes,
  - whole-pipeline freezes while the variable-latency data memory is busy.
- Contains a memory-wait FSM with a timeout watchdog, and saturating stall/flush performance counters.
- Sits beside the forwarding unit in the ID/EX control path. Its outputs drive the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
- TIMEOUT, 64: freeze cycles allowed before a memory access is declared hung; legal range 2..65535.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rstn  in  1  asynchronous active-low reset
- id_rs1  in  5  rs1 of instruction in ID
- id_rs2  in  5  rs2 of instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  rd of instruction in EX
- ex_memread  in  1  EX instruction is a load
- ex_branch_taken  in  1  branch/jump in EX resolved taken
- mem_req  in  1  MEM stage holds a load/store
- mem_ready  in  1  data memory completes access this cycle
- cnt_clr  in  1  synchronous clear of performance counters
- pc_write  out  1  PC register enable
- ifid_write  out  1  IF/ID enable
- ifid_flush  out  1  IF/ID loads a NOP
- idex_write  out  1  ID/EX enable
- idex_flush  out  1  ID/EX loads a bubble (controls zeroed)
- exmem_write  out  1  EX/MEM enable
- memwb_flush  out  1  MEM/WB loads a bubble
- mem_timeout  out  1  sticky hung-memory error
- stall_cnt  out  CNT_W  cycles with pc_write=0
- flush_cnt  out  CNT_W  cycles with a branch squash

Behaviour:

Reset (rstn=0):
- state=RUN, wait_cnt=0, mem_timeout=0, counters=0.
- Control outputs forced: all *_write=0, all *_flush=1.

Hazard terms (combinational):
- freeze = (mem_req & ~mem_ready) | (state==ERROR)
- lu = ex_memread & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))
- br = ex_branch_taken

Priority is freeze > br > lu > normal:
- freeze: pc_write=ifid_write=idex_write=exmem_write=0; memwb_flush=1; ifid_flush=idex_flush=0.
- br: all writes=1; ifid_flush=idex_flush=1; memwb_flush=0. br takes priority over lu because the ID instruction is squashed anyway.
- lu: pc_write=ifid_write=0; idex_flush=1; idex_write=exmem_write=1; ifid_flush=memwb_flush=0.
- normal: all writes=1, all flushes=0.
- A taken branch held in EX during a freeze is applied on the first unfrozen cycle, because the EX contents are frozen.

Zero latency:
- Control outputs are combinational from inputs and current state. Only state, wait_cnt, the error flag and the counters are registered.

FSM (RUN, MEM_WAIT, ERROR):
- RUN:
  - mem_req & ~mem_ready -> MEM_WAIT, wait_cnt<=1.
  - Otherwise stay in RUN.
- MEM_WAIT:
  - ~mem_req (illegal abort) -> RUN, wait_cnt<=0.
  - mem_ready -> RUN, wait_cnt<=0. That cycle is unfrozen.
  - wait_cnt==TIMEOUT-1 -> ERROR, mem_timeout<=1.
  - Otherwise wait_cnt<=wait_cnt+1.
- ERROR:
  - Absorbing until reset; the pipeline stays frozen.
- A stuck access therefore yields exactly TIMEOUT frozen cycles before ERROR is entered.

Counters:
- stall_cnt increments each cycle pc_write=0 (freeze or lu).
- flush_cnt increments each cycle br applies without freeze.
- Both saturate at all-ones.
- cnt_clr takes priority over increment (the counter reads 0 next cycle).
- mem_timeout is unaffected by cnt_clr.

Reset mid-freeze:
- Returns immediately to the reset values; no pending state survives.

Decomposition:
- hazard_pkg holds:
  - state enum ST_RUN=2'd0, ST_MEM_WAIT=2'd1, ST_ERROR=2'd2;
  - the CNT_W default;
  - a constant for the x0 register index.
- Sub-module sat_counter (params W; ports clk, rstn, clr, inc, q) is instantiated twice for stall_cnt and flush_cnt.

Test Plan:
1. Load-use: ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1, mem_req=0 for one cycle -> pc_write=0, ifid_write=0, idex_flush=1 that cycle; stall_cnt 0->1. Repeat with ex_rd=0 -> no stall.
2. Branch vs load-use: br=1 and lu true in the same cycle -> ifid_flush=1, idex_flush=1, pc_write=1; flush_cnt=1, stall_cnt unchanged.
3. Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> 3 cycles with all writes=0 and memwb_flush=1, state MEM_WAIT; 4th cycle normal with state RUN; stall_cnt=3.
4. Timeout: TIMEOUT=4, mem_req=1, mem_ready held 0 -> after 4 rising edges state=ERROR, mem_timeout=1. Later mem_ready=1 -> stays frozen. Deassert rstn -> mem_timeout=0, state=RUN.
5. Branch held under freeze: br=1 with mem_req=1, mem_ready=0 for 2 cycles -> no flush during freeze. Cycle after mem_ready=1 -> ifid_flush=idex_flush=1; flush_cnt increments by exactly 1.
6. Counter saturation/clear: CNT_W=4, 20 load-use cycles -> stall_cnt=15 held. Pulse cnt_clr with lu active -> stall_cnt=0 next cycle.
